pss_correlator_mc: RTL and testbench

Multi-sequence, runtime-loadable PSS correlator for the 5G NR receiver front end. It correlates the decimated baseband stream against up to NUM_SEQ local PSS sequences (one per N_id_2) in parallel. It outputs one squared magnitude per sequence, plus the index of the strongest sequence and per-sequence threshold-crossing flags. It replaces the single-sequence, parameter-tapped correlator and feeds the PSS peak detector / timing FSM.

---
 rtl/pss_correlator_mc_if.sv | 22 ++
 rtl/pss_correlator_mc.sv | 153 +++++++++++++++
 tb/tb_pss_correlator_mc.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pss_correlator_mc_if.sv
// Sample-in / magnitude-out streaming bus of the multi-sequence PSS correlator.
interface pss_correlator_mc_if #(
  parameter int unsigned IN_DW   = 32,
  parameter int unsigned OUT_DW  = 32,
  parameter int unsigned NUM_SEQ = 3
);
  logic [IN_DW-1:0]          s_axis_in_tdata;
  logic                      s_axis_in_tvalid;
  logic [NUM_SEQ*OUT_DW-1:0] m_axis_out_tdata;
  logic [1:0]                m_axis_out_tuser;
  logic                      m_axis_out_tvalid;

  modport master (
    output s_axis_in_tdata, s_axis_in_tvalid,
    input  m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tvalid
  );

  modport slave (
    input  s_axis_in_tdata, s_axis_in_tvalid,
    output m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tvalid
  );
endinterface

// File: rtl/pss_correlator_mc.sv
// Runtime-loadable PSS correlator: NUM_SEQ parallel complex correlations,
// saturated squared magnitudes, argmax and threshold flags, 3-cycle latency.
module pss_correlator_mc #(
  parameter int unsigned IN_DW   = 32,
  parameter int unsigned TAP_DW  = 32,
  parameter int unsigned OUT_DW  = 32,
  parameter int unsigned PSS_LEN = 127,
  parameter int unsigned NUM_SEQ = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  pss_correlator_mc_if.slave         axis,
  input  logic                       tap_wr_en_i,
  input  logic [1:0]                 tap_wr_seq_i,
  input  logic [$clog2(PSS_LEN)-1:0] tap_wr_addr_i,
  input  logic [TAP_DW-1:0]          tap_wr_data_i,
  input  logic [OUT_DW-1:0]          threshold_i,
  output logic [NUM_SEQ-1:0]         peak_o
);

  localparam int unsigned IH = IN_DW / 2;
  localparam int unsigned TH = TAP_DW / 2;
  localparam int unsigned AW = $clog2(PSS_LEN);
  localparam int unsigned SW = IH + TH + AW + 1;
  localparam int unsigned MW = 2 * SW;
  localparam int unsigned FW = $clog2(PSS_LEN + 1);
  localparam logic [OUT_DW-1:0] OMAX = '1;

  logic [IN_DW-1:0]          dly_q [PSS_LEN];
  logic [TAP_DW-1:0]         tap_q [NUM_SEQ][PSS_LEN];
  logic [FW-1:0]             fill_q;
  logic                      v0_q, v1_q;
  logic signed [SW-1:0]      sre_d [NUM_SEQ];
  logic signed [SW-1:0]      sim_d [NUM_SEQ];
  logic signed [SW-1:0]      sre_q [NUM_SEQ];
  logic signed [SW-1:0]      sim_q [NUM_SEQ];
  logic [NUM_SEQ*OUT_DW-1:0] tdata_d, tdata_q;
  logic [1:0]                tuser_d, tuser_q;
  logic [NUM_SEQ-1:0]        peak_d, peak_q;
  logic                      tvalid_q;

  function automatic logic signed [SW-1:0] ext_d(input logic [IH-1:0] x);
    return SW'(signed'(x));
  endfunction

  function automatic logic signed [SW-1:0] ext_t(input logic [TH-1:0] x);
    return SW'(signed'(x));
  endfunction

  // Stage 0: delay line, fill tracking and the fill-tagged valid token
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned k = 0; k < PSS_LEN; k++) dly_q[k] <= '0;
      fill_q <= '0;
      v0_q   <= 1'b0;
    end else begin
      if (axis.s_axis_in_tvalid) begin
        for (int unsigned k = 0; k < PSS_LEN - 1; k++) dly_q[k] <= dly_q[k+1];
        dly_q[PSS_LEN-1] <= axis.s_axis_in_tdata;
        if (fill_q != FW'(PSS_LEN)) fill_q <= fill_q + FW'(1);
      end
      v0_q <= axis.s_axis_in_tvalid && (fill_q >= FW'(PSS_LEN - 1));
    end
  end

  // Tap RAM; out-of-range seq/addr never match a storage slot
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NUM_SEQ; s++) begin
      for (int unsigned k = 0; k < PSS_LEN; k++) begin
        if (reset_i) begin
          tap_q[s][k] <= '0;
        end else if (tap_wr_en_i && tap_wr_seq_i == 2'(s) && tap_wr_addr_i == AW'(k)) begin
          tap_q[s][k] <= tap_wr_data_i;
        end
      end
    end
  end

  // Full-precision d * conj(t) accumulation per sequence
  always_comb begin
    for (int unsigned s = 0; s < NUM_SEQ; s++) begin
      sre_d[s] = '0;
      sim_d[s] = '0;
      for (int unsigned k = 0; k < PSS_LEN; k++) begin
        sre_d[s] = sre_d[s]
                 + ext_d(dly_q[k][IH-1:0])  * ext_t(tap_q[s][k][TH-1:0])
                 + ext_d(dly_q[k][IN_DW-1:IH]) * ext_t(tap_q[s][k][TAP_DW-1:TH]);
        sim_d[s] = sim_d[s]
                 + ext_d(dly_q[k][IN_DW-1:IH]) * ext_t(tap_q[s][k][TH-1:0])
                 - ext_d(dly_q[k][IH-1:0])  * ext_t(tap_q[s][k][TAP_DW-1:TH]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v1_q <= 1'b0;
      for (int unsigned s = 0; s < NUM_SEQ; s++) begin
        sre_q[s] <= '0;
        sim_q[s] <= '0;
      end
    end else begin
      v1_q <= v0_q;
      for (int unsigned s = 0; s < NUM_SEQ; s++) begin
        sre_q[s] <= sre_d[s];
        sim_q[s] <= sim_d[s];
      end
    end
  end

  // Stage 2: magnitude, saturation, lowest-index argmax, strict threshold
  always_comb begin
    logic signed [MW-1:0] wre, wim;
    logic [MW-1:0]        mag;
    logic [OUT_DW-1:0]    sat, best;
    tdata_d = '0;
    tuser_d = '0;
    peak_d  = '0;
    best    = '0;
    for (int unsigned s = 0; s < NUM_SEQ; s++) begin
      wre = MW'(sre_q[s]);
      wim = MW'(sim_q[s]);
      mag = $unsigned(wre * wre) + $unsigned(wim * wim);
      sat = (mag > MW'(OMAX)) ? OMAX : OUT_DW'(mag);
      tdata_d[s*OUT_DW +: OUT_DW] = sat;
      peak_d[s] = sat > threshold_i;
      if (sat > best) begin
        best    = sat;
        tuser_d = 2'(s);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || !v1_q) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      peak_q   <= '0;
    end else begin
      tvalid_q <= 1'b1;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      peak_q   <= peak_d;
    end
  end

  assign axis.m_axis_out_tdata  = tdata_q;
  assign axis.m_axis_out_tuser  = tuser_q;
  assign axis.m_axis_out_tvalid = tvalid_q;
  assign peak_o                 = peak_q;

endmodule

// File: tb/tb_pss_correlator_mc.sv
// Randomized scoreboard bench for pss_correlator_mc against a plain-arithmetic correlation model.
module tb_pss_correlator_mc;

  localparam int unsigned IN_DW   = 32;
  localparam int unsigned TAP_DW  = 32;
  localparam int unsigned OUT_DW  = 32;
  localparam int unsigned PSS_LEN = 127;
  localparam int unsigned NUM_SEQ = 3;
  localparam int unsigned AW      = $clog2(PSS_LEN);

  typedef struct { int re; int im; } cplx_t;
  typedef struct {
    int                        cyc;
    logic [NUM_SEQ*OUT_DW-1:0] data;
    logic [1:0]                user;
  } exp_t;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                tap_we;
  logic [1:0]          tap_seq;
  logic [AW-1:0]       tap_addr;
  logic [TAP_DW-1:0]   tap_data;
  logic [OUT_DW-1:0]   threshold;
  logic [NUM_SEQ-1:0]  peak;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  logic [OUT_DW-1:0] thr_edge = '0;
  int    tre [NUM_SEQ][PSS_LEN];
  int    tim [NUM_SEQ][PSS_LEN];
  cplx_t hist[$];
  exp_t  expq[$];
  exp_t  got_e;
  logic [NUM_SEQ-1:0] exp_pk;

  pss_correlator_mc_if #(.IN_DW(IN_DW), .OUT_DW(OUT_DW), .NUM_SEQ(NUM_SEQ)) bus ();

  pss_correlator_mc #(
    .IN_DW(IN_DW), .TAP_DW(TAP_DW), .OUT_DW(OUT_DW), .PSS_LEN(PSS_LEN), .NUM_SEQ(NUM_SEQ)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .axis(bus),
    .tap_wr_en_i(tap_we), .tap_wr_seq_i(tap_seq), .tap_wr_addr_i(tap_addr),
    .tap_wr_data_i(tap_data), .threshold_i(threshold), .peak_o(peak)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc      = cyc + 1;
    thr_edge = threshold;
  end

  function automatic logic [31:0] cx(input int re, input int im);
    return {16'(im), 16'(re)};
  endfunction

  function automatic logic [31:0] rnd_small();
    return cx(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
  endfunction

  // Reference: S_s = sum_k d[k]*conj(t[s][k]) over the last PSS_LEN accepted samples
  function automatic exp_t model_out(input int c);
    exp_t e;
    longint sr, si;
    logic signed [127:0] wr, wi;
    logic [127:0] m, maxv;
    logic [OUT_DW-1:0] v, best;
    maxv = '0;
    maxv[OUT_DW-1:0] = '1;
    e.cyc = c; e.data = '0; e.user = '0; best = '0;
    for (int s = 0; s < NUM_SEQ; s++) begin
      sr = 0; si = 0;
      for (int k = 0; k < PSS_LEN; k++) begin
        sr += longint'(hist[k].re) * longint'(tre[s][k]) + longint'(hist[k].im) * longint'(tim[s][k]);
        si += longint'(hist[k].im) * longint'(tre[s][k]) - longint'(hist[k].re) * longint'(tim[s][k]);
      end
      wr = 128'(sr);
      wi = 128'(si);
      m  = 128'(wr * wr) + 128'(wi * wi);
      v  = (m > maxv) ? maxv[OUT_DW-1:0] : m[OUT_DW-1:0];
      e.data[s*OUT_DW +: OUT_DW] = v;
      if (v > best) begin
        best   = v;
        e.user = 2'(s);
      end
    end
    return e;
  endfunction

  // Apply this cycle's driven inputs to the model, then advance one clock
  task automatic tick();
    cplx_t smp;
    if (tap_we && int'(tap_seq) < NUM_SEQ && int'(tap_addr) < PSS_LEN) begin
      tre[tap_seq][tap_addr] = int'($signed(tap_data[15:0]));
      tim[tap_seq][tap_addr] = int'($signed(tap_data[31:16]));
    end
    if (bus.s_axis_in_tvalid) begin
      smp.re = int'($signed(bus.s_axis_in_tdata[15:0]));
      smp.im = int'($signed(bus.s_axis_in_tdata[31:16]));
      hist.push_back(smp);
      if (hist.size() > PSS_LEN) void'(hist.pop_front());
      if (hist.size() == PSS_LEN) expq.push_back(model_out(cyc + 3));
    end
    @(posedge clk_i);
    #1;
    tap_we = 1'b0;
    bus.s_axis_in_tvalid = 1'b0;
    bus.s_axis_in_tdata  = '0;
  endtask

  task automatic do_reset(input int n);
    reset_i = 1'b1;
    while (expq.size() > 0 && expq[$].cyc > cyc) void'(expq.pop_back());
    hist.delete();
    for (int s = 0; s < NUM_SEQ; s++)
      for (int k = 0; k < PSS_LEN; k++) begin tre[s][k] = 0; tim[s][k] = 0; end
    for (int i = 0; i < n; i++) begin
      bus.s_axis_in_tvalid = 1'b1;
      bus.s_axis_in_tdata  = $urandom;
      tap_we = 1'b1; tap_seq = 2'd0; tap_addr = '0; tap_data = $urandom;
      @(posedge clk_i);
      #1;
    end
    reset_i = 1'b0;
    tap_we = 1'b0;
    bus.s_axis_in_tvalid = 1'b0;
  endtask

  task automatic load_seq(input int s, input logic [31:0] val);
    for (int k = 0; k < PSS_LEN; k++) begin
      tap_we = 1'b1; tap_seq = 2'(s); tap_addr = AW'(k); tap_data = val;
      tick();
    end
  endtask

  task automatic feed(input int n, input logic [31:0] val);
    for (int i = 0; i < n; i++) begin
      bus.s_axis_in_tvalid = 1'b1;
      bus.s_axis_in_tdata  = val;
      tick();
    end
  endtask

  // Monitor: pop expected entries whenever the DUT presents a valid output
  always @(negedge clk_i) begin
    if (bus.m_axis_out_tvalid === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid cyc=%0d got tvalid=1 want tvalid=0", cyc);
      end else begin
        got_e  = expq.pop_front();
        exp_pk = '0;
        for (int s = 0; s < NUM_SEQ; s++) exp_pk[s] = got_e.data[s*OUT_DW +: OUT_DW] > thr_edge;
        if (got_e.cyc != cyc || bus.m_axis_out_tdata !== got_e.data ||
            bus.m_axis_out_tuser !== got_e.user || peak !== exp_pk) begin
          bad++;
          $display("FAIL out cyc=%0d want_cyc=%0d data got=%h want=%h user got=%0d want=%0d peak got=%b want=%b",
                   cyc, got_e.cyc, bus.m_axis_out_tdata, got_e.data,
                   bus.m_axis_out_tuser, got_e.user, peak, exp_pk);
        end
      end
    end else begin
      total++;
      if (bus.m_axis_out_tvalid !== 1'b0 || bus.m_axis_out_tdata !== '0 ||
          bus.m_axis_out_tuser !== 2'd0 || peak !== '0) begin
        bad++;
        $display("FAIL idle_zero cyc=%0d got valid=%b data=%h user=%0d peak=%b want all 0",
                 cyc, bus.m_axis_out_tvalid, bus.m_axis_out_tdata, bus.m_axis_out_tuser, peak);
      end
      if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        total++;
        bad++;
        $display("FAIL missing_output cyc=%0d got tvalid=0 want tvalid=1 (due cyc=%0d)", cyc, expq[0].cyc);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    reset_i = 1'b1;
    tap_we = 1'b0; tap_seq = '0; tap_addr = '0; tap_data = '0;
    threshold = '0;
    bus.s_axis_in_tvalid = 1'b0;
    bus.s_axis_in_tdata  = '0;
    @(posedge clk_i);
    #1;
    do_reset(2);

    // Unit taps on sequence 0 with a DC input, then strict-threshold boundary
    threshold = 32'd16000;
    load_seq(0, cx(1, 0));
    feed(PSS_LEN, cx(1, 0));
    threshold = 32'd16129;
    feed(3, cx(1, 0));
    threshold = 32'd16128;
    feed(3, cx(1, 0));
    for (int i = 0; i < 4; i++) tick();

    // Conjugation on sequence 1, mid-stream reset, runtime tap update
    feed(20, rnd_small());
    do_reset(2);
    threshold = 32'd20000;
    load_seq(1, cx(0, 1));
    feed(PSS_LEN, cx(0, 1));
    feed(PSS_LEN, cx(0, -1));
    feed(60, cx(1, 0));
    bus.s_axis_in_tvalid = 1'b1; bus.s_axis_in_tdata = cx(1, 0);
    tap_we = 1'b1; tap_seq = 2'd2; tap_addr = AW'(5); tap_data = cx(3, -2);
    tick();
    bus.s_axis_in_tvalid = 1'b1; bus.s_axis_in_tdata = cx(1, 0);
    tap_we = 1'b1; tap_seq = 2'd3; tap_addr = AW'(5); tap_data = cx(100, 100);
    tick();
    bus.s_axis_in_tvalid = 1'b1; bus.s_axis_in_tdata = cx(1, 0);
    tap_we = 1'b1; tap_seq = 2'd1; tap_addr = AW'(127); tap_data = cx(100, 100);
    tick();
    feed(10, cx(1, 0));

    // Random small-amplitude taps and data with gaps and live tap writes
    do_reset(2);
    for (int s = 0; s < NUM_SEQ; s++)
      for (int k = 0; k < PSS_LEN; k++) begin
        tap_we = 1'b1; tap_seq = 2'(s); tap_addr = AW'(k); tap_data = rnd_small();
        tick();
      end
    feed(PSS_LEN, rnd_small());
    for (int i = 0; i < 40; i++) begin
      bus.s_axis_in_tvalid = (i % 2 == 0);
      bus.s_axis_in_tdata  = rnd_small();
      tick();
    end
    for (int i = 0; i < 500; i++) begin
      bus.s_axis_in_tvalid = ($urandom_range(0, 3) != 0);
      bus.s_axis_in_tdata  = rnd_small();
      if ($urandom_range(0, 9) == 0) begin
        tap_we = 1'b1; tap_seq = 2'($urandom_range(0, 3));
        tap_addr = AW'($urandom_range(0, 127)); tap_data = rnd_small();
      end
      threshold = $urandom_range(0, 1000000);
      tick();
    end

    // Full-range data drives the magnitudes into saturation
    for (int i = 0; i < 150; i++) begin
      bus.s_axis_in_tvalid = 1'b1;
      bus.s_axis_in_tdata  = $urandom;
      tap_we = 1'b1; tap_seq = 2'($urandom_range(0, 2));
      tap_addr = AW'($urandom_range(0, 126)); tap_data = $urandom;
      threshold = $urandom;
      tick();
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) tick();
    tick();
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
